// File: rtl/fifo_ctrl_pkg.sv
// Shared types and width helpers for the FIFO write-side arbitration blocks.
package fifo_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Wide enough for beat counts 0..15, i.e. bursts of up to 16 beats.
    localparam int BEAT_W = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search: returns the first asserted request at or after start_idx.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0] start_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    logic [IDX_W:0]   pos_sum_s;
    logic [IDX_W-1:0] pos_s;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        pick_idx  = IDX_W'(0);
        found     = 1'b0;
        pos_sum_s = (IDX_W + 1)'(0);
        pos_s     = IDX_W'(0);
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos_sum_s = {1'b0, start_idx} + (IDX_W + 1)'(k);
            if (pos_sum_s >= (IDX_W + 1)'(N_REQ)) begin
                pos_sum_s = pos_sum_s - (IDX_W + 1)'(N_REQ);
            end else begin
                pos_sum_s = pos_sum_s;
            end
            pos_s = pos_sum_s[IDX_W-1:0];
            if (req_vec[pos_s]) begin
                pick_idx = pos_s;
                found    = 1'b1;
            end else begin
                pick_idx = pick_idx;
                found    = found;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, credit-gated, burst-limited arbiter that funnels N write requesters
// into a single downstream synchronous FIFO write port.
module fifo_wr_arb
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 4,
    localparam int IDX_W  = idx_width(N_REQ),
    localparam int CRED_W = credit_width(FIFO_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        fifo_w_en_o,
    output logic [DATA_WIDTH-1:0]       fifo_data_o,
    input  logic                        fifo_rd_done_i,
    output logic [IDX_W-1:0]            grant_id_o,
    output logic                        grant_vld_o,
    output logic [CRED_W-1:0]           credits_o
);

    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(FIFO_DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    arb_state_e              state_r;
    logic [IDX_W-1:0]        owner_r;
    logic [IDX_W-1:0]        last_owner_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [CRED_W-1:0]       credits_r;
    logic                    w_en_r;
    logic [DATA_WIDTH-1:0]   w_data_r;

    logic [IDX_W-1:0]        start_idx_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    found_s;
    logic                    has_credit_s;
    logic                    valid_own_s;
    logic                    xfer_s;
    logic                    rd_ok_s;
    logic [DATA_WIDTH-1:0]   beat_s;
    logic [N_REQ-1:0]        req_ready_s;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_vec   (req_valid_i),
        .start_idx (start_idx_s),
        .pick_idx  (pick_idx_s),
        .found     (found_s)
    );

    // Search start, owner beat select and ready decode; ready uses registered state only.
    always_comb begin
        if (last_owner_r == IDX_LAST) begin
            start_idx_s = IDX_W'(0);
        end else begin
            start_idx_s = last_owner_r + IDX_W'(1);
        end
        has_credit_s = (credits_r != CRED_W'(0));
        valid_own_s  = req_valid_i[owner_r];
        xfer_s       = (state_r == ST_GRANT) && has_credit_s && valid_own_s;
        rd_ok_s      = fifo_rd_done_i && (credits_r != CRED_MAX);
        beat_s       = DATA_WIDTH'(0);
        req_ready_s  = N_REQ'(0);
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_r == IDX_W'(i)) begin
                beat_s         = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready_s[i] = (state_r == ST_GRANT) && has_credit_s;
            end else begin
                beat_s         = beat_s;
                req_ready_s[i] = 1'b0;
            end
        end
    end

    // Arbitration FSM, credit counter and registered FIFO write port.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= IDX_W'(0);
            last_owner_r <= IDX_LAST;
            beat_cnt_r   <= BEAT_W'(0);
            credits_r    <= CRED_MAX;
            w_en_r       <= 1'b0;
            w_data_r     <= DATA_WIDTH'(0);
        end else begin
            w_en_r <= xfer_s;
            if (xfer_s) begin
                w_data_r <= beat_s;
            end

            if (xfer_s && !rd_ok_s) begin
                credits_r <= credits_r - CRED_W'(1);
            end else if (!xfer_s && rd_ok_s) begin
                credits_r <= credits_r + CRED_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= BEAT_W'(0);
                        state_r    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Out of credits: freeze the grant until the FIFO drains an entry.
                    if (!has_credit_s) begin
                        beat_cnt_r <= beat_cnt_r;
                    end else if (!valid_own_s || (beat_cnt_r == BEAT_LAST)) begin
                        last_owner_r <= owner_r;
                        beat_cnt_r   <= BEAT_W'(0);
                        state_r      <= ST_IDLE;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_s;
    assign fifo_w_en_o = w_en_r;
    assign fifo_data_o = w_data_r;
    assign grant_id_o  = owner_r;
    assign grant_vld_o = (state_r == ST_GRANT);
    assign credits_o   = credits_r;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: a vector table for the basic burst flow plus
// hand-written sequences for round-robin, credit, release and reset corners.
module tb_fifo_wr_arb;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ready_o;
    logic         fifo_w_en_o;
    logic [31:0]  fifo_data_o;
    logic         fifo_rd_done_i;
    logic [1:0]   grant_id_o;
    logic         grant_vld_o;
    logic [4:0]   credits_o;

    int n_vec  = 0;
    int n_fail = 0;

    fifo_wr_arb #(
        .N_REQ      (4),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (16),
        .BURST_LEN  (4)
    ) dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_w_en_o    (fifo_w_en_o),
        .fifo_data_o    (fifo_data_o),
        .fifo_rd_done_i (fifo_rd_done_i),
        .grant_id_o     (grant_id_o),
        .grant_vld_o    (grant_vld_o),
        .credits_o      (credits_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] d0;
        logic        rd;
        logic [3:0]  ready;
        logic        wen;
        logic [31:0] wdata;
        logic [1:0]  gid;
        logic        gvld;
        logic [4:0]  cred;
    } vec_t;

    vec_t vt[11];

    function automatic logic [31:0] lane_word(input int i);
        return 32'hA000_0000 + 32'(i * 32'h0000_0101);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_lanes();
        for (int i = 0; i < 4; i++) req_data_i[i*32 +: 32] = lane_word(i);
    endtask

    task automatic do_reset();
        resetn_i       = 1'b0;
        req_valid_i    = 4'b0000;
        fifo_rd_done_i = 1'b0;
        set_lanes();
        step();
        step();
        resetn_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_w;
        int cyc;
        int own;

        //           valid    d0             rd    ready    wen   wdata          gid   gvld  cred
        vt[0]  = '{4'b0001, 32'hD000_0000, 1'b0, 4'b0001, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 5'd15};
        vt[1]  = '{4'b0001, 32'hD000_0000, 1'b0, 4'b0001, 1'b1, 32'hD000_0000, 2'd0, 1'b1, 5'd14};
        vt[2]  = '{4'b0001, 32'hD000_0001, 1'b0, 4'b0001, 1'b1, 32'hD000_0001, 2'd0, 1'b1, 5'd13};
        vt[3]  = '{4'b0001, 32'hD000_0002, 1'b0, 4'b0001, 1'b1, 32'hD000_0002, 2'd0, 1'b1, 5'd12};
        vt[4]  = '{4'b0001, 32'hD000_0003, 1'b0, 4'b0000, 1'b1, 32'hD000_0003, 2'd0, 1'b0, 5'd11};
        vt[5]  = '{4'b0001, 32'hD000_0004, 1'b0, 4'b0001, 1'b0, 32'hD000_0003, 2'd0, 1'b1, 5'd11};
        vt[6]  = '{4'b0001, 32'hD000_0004, 1'b0, 4'b0001, 1'b1, 32'hD000_0004, 2'd0, 1'b1, 5'd10};
        vt[7]  = '{4'b0001, 32'hD000_0005, 1'b0, 4'b0001, 1'b1, 32'hD000_0005, 2'd0, 1'b1, 5'd9};
        vt[8]  = '{4'b0000, 32'hD000_0005, 1'b0, 4'b0000, 1'b0, 32'hD000_0005, 2'd0, 1'b0, 5'd9};
        vt[9]  = '{4'b0000, 32'hD000_0005, 1'b0, 4'b0000, 1'b0, 32'hD000_0005, 2'd0, 1'b0, 5'd9};
        vt[10] = '{4'b0000, 32'hD000_0005, 1'b1, 4'b0000, 1'b0, 32'hD000_0005, 2'd0, 1'b0, 5'd10};

        // Reset state.
        do_reset();
        chk("rst ready", 32'(req_ready_o), 32'h0);
        chk("rst wen",   32'(fifo_w_en_o), 32'h0);
        chk("rst wdata", fifo_data_o,      32'h0);
        chk("rst gid",   32'(grant_id_o),  32'h0);
        chk("rst gvld",  32'(grant_vld_o), 32'h0);
        chk("rst cred",  32'(credits_o),   32'd15);

        // Single requester, six beats split into a 4-beat and a 2-beat grant.
        for (int i = 0; i < 11; i++) begin
            req_valid_i       = vt[i].valid;
            req_data_i[31:0]  = vt[i].d0;
            fifo_rd_done_i    = vt[i].rd;
            step();
            chk($sformatf("v%0d ready", i), 32'(req_ready_o), 32'(vt[i].ready));
            chk($sformatf("v%0d wen", i),   32'(fifo_w_en_o), 32'(vt[i].wen));
            chk($sformatf("v%0d wdata", i), fifo_data_o,      vt[i].wdata);
            chk($sformatf("v%0d gid", i),   32'(grant_id_o),  32'(vt[i].gid));
            chk($sformatf("v%0d gvld", i),  32'(grant_vld_o), 32'(vt[i].gvld));
            chk($sformatf("v%0d cred", i),  32'(credits_o),   32'(vt[i].cred));
        end
        fifo_rd_done_i = 1'b0;

        // All requesters valid: owners 0,1,2,3,0, four beats each, one bubble between.
        do_reset();
        req_valid_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            own = g % 4;
            step();
            chk($sformatf("rr%0d gvld", g),  32'(grant_vld_o), 32'h1);
            chk($sformatf("rr%0d gid", g),   32'(grant_id_o),  32'(own));
            chk($sformatf("rr%0d ready", g), 32'(req_ready_o), 32'(1 << own));
            chk($sformatf("rr%0d wen0", g),  32'(fifo_w_en_o), 32'h0);
            for (int b = 0; b < 4; b++) begin
                fifo_rd_done_i = (g > 0);
                step();
                chk($sformatf("rr%0d.%0d wen", g, b),   32'(fifo_w_en_o), 32'h1);
                chk($sformatf("rr%0d.%0d wdata", g, b), fifo_data_o,      lane_word(own));
                chk($sformatf("rr%0d.%0d cred", g, b),  32'(credits_o),   (g == 0) ? 32'(14 - b) : 32'd11);
                chk($sformatf("rr%0d.%0d ready", g, b), 32'(req_ready_o), (b < 3) ? 32'(1 << own) : 32'h0);
            end
            fifo_rd_done_i = 1'b0;
            chk($sformatf("rr%0d release", g), 32'(grant_vld_o), 32'h0);
        end

        // Credit exhaustion: 15 beats drain all credits, one rd_done admits exactly one more.
        do_reset();
        req_valid_i = 4'b0001;
        n_w = 0;
        cyc = 0;
        while (n_w < 15 && cyc < 200) begin
            step();
            cyc++;
            if (fifo_w_en_o) n_w++;
        end
        chk("cr writes",   32'(n_w),         32'd15);
        chk("cr cred0",    32'(credits_o),   32'd0);
        chk("cr ready0",   32'(req_ready_o), 32'h0);
        chk("cr held",     32'(grant_vld_o), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("cr stall%0d wen", k),  32'(fifo_w_en_o), 32'h0);
            chk($sformatf("cr stall%0d gvld", k), 32'(grant_vld_o), 32'h1);
        end
        fifo_rd_done_i = 1'b1;
        step();
        fifo_rd_done_i = 1'b0;
        chk("cr cred1",  32'(credits_o),   32'd1);
        chk("cr ready1", 32'(req_ready_o), 32'b0001);
        n_w = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (fifo_w_en_o) n_w++;
        end
        chk("cr one more", 32'(n_w),       32'd1);
        chk("cr cred end", 32'(credits_o), 32'd0);

        // Transfer and rd_done in the same cycle at five credits.
        do_reset();
        req_valid_i = 4'b0001;
        cyc = 0;
        while (credits_o != 5'd5 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("net cred5",  32'(credits_o),   32'd5);
        chk("net ready",  32'(req_ready_o), 32'b0001);
        fifo_rd_done_i = 1'b1;
        step();
        fifo_rd_done_i = 1'b0;
        chk("net wen",    32'(fifo_w_en_o), 32'h1);
        chk("net hold5",  32'(credits_o),   32'd5);
        step();
        chk("net cred4",  32'(credits_o),   32'd4);

        // Owner 2 drops valid after one beat; requester 3 takes over after one bubble.
        do_reset();
        req_valid_i = 4'b0100;
        step();
        chk("drop gid2",   32'(grant_id_o),  32'd2);
        chk("drop gvld",   32'(grant_vld_o), 32'h1);
        req_valid_i = 4'b1100;
        step();
        chk("drop wen",    32'(fifo_w_en_o), 32'h1);
        chk("drop wdata",  fifo_data_o,      lane_word(2));
        req_valid_i = 4'b1000;
        step();
        chk("drop idle",   32'(grant_vld_o), 32'h0);
        chk("drop nowen",  32'(fifo_w_en_o), 32'h0);
        chk("drop gidh",   32'(grant_id_o),  32'd2);
        step();
        chk("drop gid3",   32'(grant_id_o),  32'd3);
        chk("drop gvld3",  32'(grant_vld_o), 32'h1);
        chk("drop ready3", 32'(req_ready_o), 32'b1000);

        // Reset during the third beat of a grant.
        do_reset();
        req_valid_i = 4'b0011;
        step();
        step();
        step();
        chk("mr pre cred", 32'(credits_o), 32'd13);
        resetn_i = 1'b0;
        step();
        chk("mr wen",   32'(fifo_w_en_o), 32'h0);
        chk("mr wdata", fifo_data_o,      32'h0);
        chk("mr cred",  32'(credits_o),   32'd15);
        chk("mr gvld",  32'(grant_vld_o), 32'h0);
        chk("mr ready", 32'(req_ready_o), 32'h0);
        chk("mr gid",   32'(grant_id_o),  32'd0);
        resetn_i = 1'b1;
        step();
        chk("mr regrant gid",  32'(grant_id_o),  32'd0);
        chk("mr regrant gvld", 32'(grant_vld_o), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter: N_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter: DATA_WIDTH, default 32, beat width.
REQ-003 Parameter: FIFO_DEPTH, default 16, downstream FIFO entry count; usable credits = FIFO_DEPTH-1.
REQ-004 Parameter: BURST_LEN, default 4, max consecutive beats per grant (1..16).
REQ-005 clk_i  in  1  single clock, all logic on rising edge.
REQ-006 resetn_i  in  1  reset, synchronous, active-low.
REQ-007 req_valid_i  in  N_REQ  per-requester beat valid.
REQ-008 req_data_i  in  N_REQ*DATA_WIDTH  per-requester beat, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready_o  out  N_REQ  per-requester accept.
REQ-010 fifo_w_en_o  out  1  registered FIFO write strobe.
REQ-011 fifo_data_o  out  DATA_WIDTH  registered FIFO write data.
REQ-012 fifo_rd_done_i  in  1  one-cycle pulse per entry popped from the FIFO.
REQ-013 grant_id_o  out  clog2(N_REQ)  current owner index.
REQ-014 grant_vld_o  out  1  high in GRANT state.
REQ-015 credits_o  out  clog2(FIFO_DEPTH)+1  free-entry credit count.

Function
REQ-016 Transfer on requester i SHALL occur when req_valid_i[i] && req_ready_o[i].
REQ-017 req_ready_o[i] SHALL be high only when state==GRANT, grant_id_o==i, credits_o>0; all other bits low; ready never depends on req_valid_i.
REQ-018 A transfer SHALL register fifo_w_en_o=1 and fifo_data_o=accepted beat next cycle (latency 1); otherwise fifo_w_en_o=0 and fifo_data_o holds.
REQ-019 States: IDLE, GRANT.
REQ-020 IDLE: if any req_valid_i, owner <= first valid index searching circularly from last_owner+1, beat count <= 0, state <= GRANT; else stay IDLE.
REQ-021 GRANT: each transfer increments beat count; release when transfer with beat count==BURST_LEN-1, or req_valid_i[owner]==0; release sets last_owner<=owner, state<=IDLE (one bubble cycle between grants).
REQ-022 GRANT with credits_o==0 SHALL hold grant without release or beat count change.
REQ-023 Credits: -1 per transfer, +1 per fifo_rd_done_i, net 0 when both same cycle; never below 0 or above FIFO_DEPTH-1.
REQ-024 fifo_rd_done_i with credits_o==FIFO_DEPTH-1 SHALL be ignored (saturate).
REQ-025 Round-robin index arithmetic SHALL wrap modulo N_REQ, including non-power-of-two N_REQ.
REQ-026 grant_id_o SHALL hold last owner value while in IDLE.

Reset
REQ-027 resetn_i low at a clock edge SHALL set state=IDLE, last_owner=N_REQ-1, grant_id_o=0, beat count=0, credits_o=FIFO_DEPTH-1, fifo_w_en_o=0, fifo_data_o=0, req_ready_o=0, grant_vld_o=0.
REQ-028 Reset mid-burst SHALL discard the in-progress grant; a beat accepted in the reset cycle SHALL NOT be written.

Structure
REQ-029 State encoding and credit-width/index-width constants SHALL live in shared package fifo_ctrl_pkg.
REQ-030 Circular first-valid search SHALL be sub-module rr_pick (combinational, inputs req vector and start index, outputs index and found).
REQ-031 Block instantiates no FIFO; it sits in front of fifo_sync with fifo_w_en_o/fifo_data_o driving it.

Verification
REQ-032 Reset, then req_valid_i=4'b0001 for 6 beats D0..D5 -> grant 0, beats D0..D3, IDLE bubble, grant 0 again, D4..D5, credits_o 15->9.
REQ-033 req_valid_i=4'b1111 continuous, BURST_LEN=4 -> owner order 0,1,2,3,0; 4 beats each; one idle cycle between grants.
REQ-034 15 transfers with no fifo_rd_done_i -> credits_o=0, req_ready_o=0 while grant held; one rd_done pulse -> exactly one more beat accepted.
REQ-035 Transfer and fifo_rd_done_i same cycle at credits_o=5 -> credits_o stays 5.
REQ-036 Owner 2 drops req_valid_i after 1 beat, requester 3 valid -> release, IDLE one cycle, grant 3.
REQ-037 resetn_i low during beat 2 of a grant -> fifo_w_en_o=0 next cycle, credits_o=15, state IDLE, next grant to requester 0.
